// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, constants and helpers for the DMA ring writer
//
// Purpose: FSM state encoding, the 4 KB AXI boundary constant and the
// min / clog2 helpers used by dma_ring_writer.
// Ports: none (package).

package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP1,
    ST_PREP2,
    ST_WAIT_FIFO,
    ST_BURST,
    ST_DRAIN,
    ST_DONE
  } dma_state_e;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_buf_v.sv
// rtl/stream_buf_v.sv - two-entry skid buffer with fully registered outputs
//
// Purpose: breaks the ready/valid timing path of a stream; in_tready comes
// straight from a flop and the output side is a register.
// Ports:
//   clk, rst              clock, synchronous active-high reset (flushes)
//   in_tvalid/in_tready   upstream handshake, in_tdata payload
//   out_tvalid/out_tready downstream handshake, out_tdata payload
//   empty                 high when neither entry holds data

module stream_buf_v #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [Width-1:0] in_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [Width-1:0] out_tdata,
  output logic             empty
);

  logic             skid_valid;
  logic [Width-1:0] skid_data;

  // Upstream may push whenever the overflow entry is free.
  assign in_tready = !skid_valid;
  assign empty     = !out_tvalid && !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      skid_valid <= 1'b0;
      out_tdata  <= '0;
      skid_data  <= '0;
    end else if (!out_tvalid || out_tready) begin
      // Output slot frees up: refill from the skid entry first to keep order.
      if (skid_valid) begin
        out_tdata  <= skid_data;
        out_tvalid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_tdata  <= in_tdata;
        out_tvalid <= in_tvalid;
      end
    end else if (in_tvalid && in_tready) begin
      // Output stalled: park the accepted word.
      skid_data  <= in_tdata;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_ring_writer.sv
// rtl/dma_ring_writer.sv - streams input words into a memory buffer over AXI4 write bursts
//
// Purpose: writes din words to [cfg_base, cfg_base + cfg_len words), split
// into bursts that never cross 4 KB, optionally wrapping back to the base
// (ring mode) until a graceful stop.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cfg_base/len/burst/ring/valid    run configuration and start request
//   cfg_stop                         graceful stop request
//   cfg_busy/done/wraps/err          status: not idle, completion pulse,
//                                    saturating wrap count, sticky bresp
//   din_valid/ready/data/fifo_used   input stream and upstream FIFO level
//   mst_aw*, mst_w*, mst_b*          AXI4 write master channels

module dma_ring_writer
  import dma_pkg::*;
#(
  parameter int DataBits       = 64,
  parameter int AddrBits       = 32,
  parameter int LengthBits     = 20,
  parameter int FifoUsedBits   = 10,
  parameter int MaxOutstanding = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddrBits-1:0]     cfg_base,
  input  logic [LengthBits-1:0]   cfg_len,
  input  logic [8:0]              cfg_burst,
  input  logic                    cfg_ring,
  input  logic                    cfg_valid,
  input  logic                    cfg_stop,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic [15:0]             cfg_wraps,
  output logic [1:0]              cfg_err,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DataBits-1:0]     din_data,
  input  logic [FifoUsedBits-1:0] din_fifo_used,
  output logic                    mst_awvalid,
  input  logic                    mst_awready,
  output logic [AddrBits-1:0]     mst_awaddr,
  output logic [7:0]              mst_awlen,
  output logic [2:0]              mst_awsize,
  output logic [1:0]              mst_awburst,
  output logic                    mst_wvalid,
  input  logic                    mst_wready,
  output logic [DataBits-1:0]     mst_wdata,
  output logic [DataBits/8-1:0]   mst_wstrb,
  output logic                    mst_wlast,
  input  logic                    mst_bvalid,
  output logic                    mst_bready,
  input  logic [1:0]              mst_bresp
);

  localparam int StrbBits  = DataBits / 8;
  localparam int ByteShift = clog2_u(StrbBits);
  localparam int OutBits   = clog2_u(MaxOutstanding + 1);

  dma_state_e            state;
  logic [AddrBits-1:0]   base_r;
  logic [AddrBits-1:0]   addr;
  logic [LengthBits-1:0] len_r;
  logic [LengthBits-1:0] remain;
  logic [LengthBits-1:0] seg_len;
  logic [12:0]           words_to_4k;
  logic [8:0]            burst_cfg_r;
  logic [8:0]            burst_len;
  logic [8:0]            beat_cnt;
  logic                  ring_r;
  logic                  stop_pending;
  logic [OutBits-1:0]    outstanding;

  logic stop_req;
  logic aw_ok;
  logic aw_issue;
  logic b_fire;
  logic din_fire;
  logic last_beat;
  logic buf_in_ready;
  logic buf_empty;

  assign stop_req  = stop_pending || cfg_stop;
  assign aw_ok     = (32'(din_fifo_used) >= 32'(burst_len))
                  && (32'(outstanding) < 32'(MaxOutstanding))
                  && (!mst_awvalid || mst_awready);
  assign aw_issue  = (state == ST_WAIT_FIFO) && !stop_req && aw_ok;
  // Responses arriving after a reset have no matching burst; swallow them.
  assign b_fire    = mst_bvalid && (outstanding != '0);
  assign din_ready = (state == ST_BURST) && buf_in_ready;
  assign din_fire  = din_valid && din_ready;
  assign last_beat = (beat_cnt == burst_len - 9'd1);

  assign cfg_busy    = (state != ST_IDLE);
  assign mst_awsize  = 3'(ByteShift);
  assign mst_awburst = AXI_BURST_INCR;
  assign mst_wstrb   = '1;
  assign mst_bready  = 1'b1;

  stream_buf_v #(
    .Width(DataBits + 1)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .in_tvalid (din_valid && (state == ST_BURST)),
    .in_tready (buf_in_ready),
    .in_tdata  ({last_beat, din_data}),
    .out_tvalid(mst_wvalid),
    .out_tready(mst_wready),
    .out_tdata ({mst_wlast, mst_wdata}),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mst_awvalid  <= 1'b0;
      mst_awaddr   <= '0;
      mst_awlen    <= '0;
      cfg_done     <= 1'b0;
      cfg_err      <= 2'b00;
      cfg_wraps    <= '0;
      outstanding  <= '0;
      remain       <= '0;
      stop_pending <= 1'b0;
      base_r       <= '0;
      addr         <= '0;
      len_r        <= '0;
      seg_len      <= '0;
      words_to_4k  <= '0;
      burst_cfg_r  <= '0;
      burst_len    <= '0;
      beat_cnt     <= '0;
      ring_r       <= 1'b0;
    end else begin
      cfg_done <= 1'b0;

      // AW stays asserted with stable fields until accepted.
      if (mst_awvalid && mst_awready) mst_awvalid <= 1'b0;
      if (aw_issue) begin
        mst_awvalid <= 1'b1;
        mst_awaddr  <= addr;
        mst_awlen   <= 8'(burst_len - 9'd1);
      end

      case ({aw_issue, b_fire})
        2'b10:   outstanding <= outstanding + OutBits'(1);
        2'b01:   outstanding <= outstanding - OutBits'(1);
        default: outstanding <= outstanding;
      endcase

      if (state == ST_IDLE && cfg_valid) cfg_err <= 2'b00;
      else if (b_fire && mst_bresp != 2'b00 && cfg_err == 2'b00) cfg_err <= mst_bresp;

      if (state == ST_DONE) stop_pending <= 1'b0;
      else if (cfg_stop && state != ST_IDLE) stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            base_r      <= cfg_base;
            addr        <= cfg_base;
            len_r       <= cfg_len;
            remain      <= cfg_len;
            burst_cfg_r <= cfg_burst;
            ring_r      <= cfg_ring;
            state       <= (cfg_len == '0) ? ST_DONE : ST_PREP1;
          end
        end
        ST_PREP1: begin
          seg_len     <= LengthBits'(min_u(32'(remain), 32'(burst_cfg_r)));
          words_to_4k <= 13'((BOUNDARY_BYTES - 32'(addr[11:0])) >> ByteShift);
          state       <= ST_PREP2;
        end
        ST_PREP2: begin
          burst_len <= 9'(min_u(32'(seg_len), 32'(words_to_4k)));
          state     <= ST_WAIT_FIFO;
        end
        ST_WAIT_FIFO: begin
          if (stop_req) begin
            state <= ST_DRAIN;
          end else if (aw_ok) begin
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (din_fire) begin
            addr     <= addr + AddrBits'(StrbBits);
            remain   <= remain - LengthBits'(1);
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) begin
              if (stop_req) begin
                state <= ST_DRAIN;
              end else if (remain != LengthBits'(1)) begin
                state <= ST_PREP1;
              end else if (ring_r) begin
                addr   <= base_r;
                remain <= len_r;
                if (cfg_wraps != 16'hFFFF) cfg_wraps <= cfg_wraps + 16'd1;
                state  <= ST_PREP1;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0 && buf_empty) begin
            cfg_done <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ring_writer.sv
// tb/tb_dma_ring_writer.sv - self-checking bench for dma_ring_writer

module tb_dma_ring_writer;

  localparam int DW = 64;
  localparam int MO = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  len;
  } aw_exp_t;

  typedef struct {
    logic [31:0] base;
    logic [19:0] len;
    logic [8:0]  burst;
    int          slverr_idx;
    int          exp_bursts;
    logic [1:0]  exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_base = '0;
  logic [19:0]   cfg_len = '0;
  logic [8:0]    cfg_burst = '0;
  logic          cfg_ring = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_stop = 1'b0;
  logic          cfg_busy, cfg_done;
  logic [15:0]   cfg_wraps;
  logic [1:0]    cfg_err;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] din_data = '0;
  logic [9:0]    din_fifo_used = 10'd512;
  logic          mst_awvalid;
  logic          mst_awready = 1'b0;
  logic [31:0]   mst_awaddr;
  logic [7:0]    mst_awlen;
  logic [2:0]    mst_awsize;
  logic [1:0]    mst_awburst;
  logic          mst_wvalid;
  logic          mst_wready = 1'b0;
  logic [DW-1:0] mst_wdata;
  logic [7:0]    mst_wstrb;
  logic          mst_wlast;
  logic          mst_bvalid = 1'b0;
  logic          mst_bready;
  logic [1:0]    mst_bresp = 2'b00;

  always #5 clk = ~clk;

  dma_ring_writer #(.MaxOutstanding(MO)) dut (
    .clk(clk), .rst(rst),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_burst(cfg_burst), .cfg_ring(cfg_ring),
    .cfg_valid(cfg_valid), .cfg_stop(cfg_stop), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_wraps(cfg_wraps), .cfg_err(cfg_err),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_fifo_used(din_fifo_used),
    .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen),
    .mst_awsize(mst_awsize), .mst_awburst(mst_awburst),
    .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb),
    .mst_wlast(mst_wlast),
    .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bresp(mst_bresp)
  );

  int n_vec = 0;
  int n_err = 0;

  aw_exp_t     exp_aw_q[$];
  logic        exp_last_q[$];
  logic [63:0] exp_w_q[$];
  logic [1:0]  b_pend[$];

  int          aw_run, b_run, done_cnt, wl_cnt, din_words, b_at_done;
  int          aw_hs = 0, b_hs = 0;
  int          slverr_idx = -1;
  logic        hold_b = 1'b0;
  logic [31:0] src_cnt = '0;
  logic [31:0] aw_log_addr[16];
  logic [7:0]  aw_log_len[16];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Slave / source model: decides this cycle's inputs at the negedge, then
  // scores every handshake that will complete on the following posedge.
  initial begin
    aw_exp_t     e;
    logic [63:0] wd;
    logic        wl;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_aw_q.delete(); exp_last_q.delete(); exp_w_q.delete(); b_pend.delete();
        aw_hs = 0; b_hs = 0;
        mst_awready = 1'b0; mst_wready = 1'b0; mst_bvalid = 1'b0; din_valid = 1'b0;
        continue;
      end
      mst_awready = ($urandom_range(0, 3) != 0);
      mst_wready  = ($urandom_range(0, 3) != 0);
      din_valid   = ($urandom_range(0, 4) != 0);
      din_data    = {32'hA5A5_0000 ^ src_cnt, src_cnt};
      mst_bvalid  = 1'b0;
      if (!hold_b && b_pend.size() > 0 && b_hs < aw_hs) begin
        mst_bvalid = 1'b1;
        mst_bresp  = b_pend[0];
      end
      if (cfg_done) begin
        done_cnt++;
        b_at_done = b_run;
      end
      if (mst_awvalid && mst_awready) begin
        check("aw_outstanding_le_max", 64'((aw_hs + 1 - b_hs) <= MO), 64'd1);
        if (exp_aw_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL aw_unexpected: got addr 0x%0h want no burst", mst_awaddr);
        end else begin
          e = exp_aw_q.pop_front();
          check("aw_addr", mst_awaddr, e.addr);
          check("aw_len", mst_awlen, e.len - 9'd1);
        end
        if (aw_run < 16) begin
          aw_log_addr[aw_run] = mst_awaddr;
          aw_log_len[aw_run]  = mst_awlen;
        end
        aw_run++; aw_hs++;
      end
      if (mst_wvalid && mst_wready) begin
        if (exp_w_q.size() == 0 || exp_last_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL w_unexpected: got data 0x%0h want no beat", mst_wdata);
        end else begin
          wd = exp_w_q.pop_front();
          wl = exp_last_q.pop_front();
          check("w_data", mst_wdata, wd);
          check("w_last", mst_wlast, wl);
        end
        if (mst_wlast) begin
          b_pend.push_back((wl_cnt == slverr_idx) ? 2'b10 : 2'b00);
          wl_cnt++;
        end
      end
      if (din_valid && din_ready) begin
        exp_w_q.push_back(din_data);
        src_cnt++;
        din_words++;
      end
      if (mst_bvalid) begin
        void'(b_pend.pop_front());
        b_hs++;
        b_run++;
      end
    end
  end

  // Reference burst split: largest burst bounded by remaining words, the
  // configured maximum and the distance to the next 4 KB page.
  task automatic load_exp(input logic [31:0] base, input logic [19:0] len,
                          input logic [8:0] burst, input int passes);
    for (int p = 0; p < passes; p++) begin
      logic [31:0] a;
      int rem;
      a = base;
      rem = int'(len);
      while (rem > 0) begin
        int to4k;
        int b;
        to4k = (4096 - int'(a[11:0])) / 8;
        b = rem;
        if (int'(burst) < b) b = int'(burst);
        if (to4k < b) b = to4k;
        exp_aw_q.push_back('{a, 9'(b)});
        for (int k = 0; k < b; k++) exp_last_q.push_back(k == b - 1);
        a = a + 32'(b * 8);
        rem -= b;
      end
    end
  endtask

  task automatic start_run(input logic [31:0] base, input logic [19:0] len,
                           input logic [8:0] burst, input logic ring);
    aw_run = 0; b_run = 0; done_cnt = 0; wl_cnt = 0; din_words = 0; b_at_done = -1;
    cfg_base = base; cfg_len = len; cfg_burst = burst; cfg_ring = ring;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("busy_after_start", cfg_busy, 1'b1);
  endtask

  task automatic wait_done(input int max_cycles);
    int t;
    t = 0;
    while (done_cnt == 0 && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("idle_after_done", cfg_busy, 1'b0);
  endtask

  task automatic check_queues_empty();
    check("aw_left", exp_aw_q.size(), 0);
    check("w_left", exp_w_q.size(), 0);
    check("wlast_left", exp_last_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    slverr_idx = v.slverr_idx;
    load_exp(v.base, v.len, v.burst, 1);
    start_run(v.base, v.len, v.burst, 1'b0);
    wait_done(5000);
    check("aw_count", aw_run, v.exp_bursts);
    check("b_count_at_done", b_at_done, v.exp_bursts);
    check("cfg_err", cfg_err, v.exp_err);
    check_queues_empty();
  endtask

  initial begin
    int t;
    vecs[0] = '{32'h0000_1000, 20'd40,  9'd16,  -1, 3, 2'b00};
    vecs[1] = '{32'h0000_0FE0, 20'd16,  9'd16,  -1, 2, 2'b00};
    vecs[2] = '{32'h0000_3000, 20'd48,  9'd16,   1, 3, 2'b10};
    vecs[3] = '{32'h0000_4000, 20'd5,   9'd256, -1, 1, 2'b00};
    vecs[4] = '{32'h0000_5F00, 20'd300, 9'd256, -1, 3, 2'b00};
    vecs[5] = '{32'hFFFF_FFC0, 20'd16,  9'd8,   -1, 2, 2'b00};
    vecs[6] = '{32'h0000_7000, 20'd512, 9'd256, -1, 2, 2'b00};
    vecs[7] = '{32'h0000_A000, 20'd40,  9'd16,  -1, 3, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_wraps", cfg_wraps, 16'd0);
    check("rst_err", cfg_err, 2'b00);
    check("rst_awvalid", mst_awvalid, 1'b0);
    check("rst_wvalid", mst_wvalid, 1'b0);
    check("rst_din_ready", din_ready, 1'b0);
    check("bready_tied", mst_bready, 1'b1);
    check("awsize", mst_awsize, 3'd3);
    check("awburst", mst_awburst, 2'b01);
    check("wstrb", mst_wstrb, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-pass runs
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        check("v0_aw0_addr", aw_log_addr[0], 32'h1000); check("v0_aw0_len", aw_log_len[0], 8'd15);
        check("v0_aw1_addr", aw_log_addr[1], 32'h1080); check("v0_aw1_len", aw_log_len[1], 8'd15);
        check("v0_aw2_addr", aw_log_addr[2], 32'h1100); check("v0_aw2_len", aw_log_len[2], 8'd7);
      end
      if (i == 1) begin
        check("v1_aw0_addr", aw_log_addr[0], 32'h0FE0); check("v1_aw0_len", aw_log_len[0], 8'd3);
        check("v1_aw1_addr", aw_log_addr[1], 32'h1000); check("v1_aw1_len", aw_log_len[1], 8'd11);
      end
      if (i == 6) check("v6_awlen_256", aw_log_len[0], 8'd255);
      check("wraps_single_pass", cfg_wraps, 16'd0);
    end

    // FIFO level gates AW; stop while waiting goes straight to drain
    slverr_idx = -1;
    din_fifo_used = 10'd8;
    start_run(32'h0000_C000, 20'd16, 9'd16, 1'b0);
    repeat (20) @(negedge clk);
    check("gated_no_aw", aw_run, 0);
    check("gated_din_ready", din_ready, 1'b0);
    check("gated_busy", cfg_busy, 1'b1);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_done(200);
    check("stop_wait_no_aw", aw_run, 0);
    check("stop_wait_no_words", din_words, 0);
    din_fifo_used = 10'd512;

    // Outstanding limit with responses withheld
    hold_b = 1'b1;
    load_exp(32'h0000_B000, 20'd48, 9'd16, 1);
    start_run(32'h0000_B000, 20'd48, 9'd16, 1'b0);
    t = 0;
    while (aw_run < 2 && t < 1000) begin @(negedge clk); t++; end
    repeat (60) @(negedge clk);
    check("held_b_aw_count", aw_run, 2);
    check("held_b_busy", cfg_busy, 1'b1);
    hold_b = 1'b0;
    wait_done(2000);
    check("released_aw_count", aw_run, 3);
    check_queues_empty();

    // Ring mode, stop after 100 words
    load_exp(32'h0000_8000, 20'd32, 9'd16, 5);
    start_run(32'h0000_8000, 20'd32, 9'd16, 1'b1);
    t = 0;
    while (din_words < 100 && t < 3000) begin @(negedge clk); t++; end
    check("ring_reached_100", 64'(din_words >= 100), 64'd1);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_done(3000);
    check("ring_aw_count", aw_run, 7);
    check("ring_wraps", cfg_wraps, 16'd3);
    check("ring_words", din_words, 112);
    check("ring_w_left", exp_w_q.size(), 0);
    exp_aw_q.delete(); exp_last_q.delete();

    // Reset on beat 5 of a 16-beat burst, then a clean run
    load_exp(32'h0000_9000, 20'd64, 9'd16, 1);
    start_run(32'h0000_9000, 20'd64, 9'd16, 1'b0);
    t = 0;
    while (din_words < 5 && t < 1000) begin @(negedge clk); t++; end
    check("reached_beat5", 64'(din_words >= 5), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", cfg_busy, 1'b0);
    check("mid_rst_awvalid", mst_awvalid, 1'b0);
    check("mid_rst_awaddr", mst_awaddr, 32'd0);
    check("mid_rst_wvalid", mst_wvalid, 1'b0);
    check("mid_rst_din_ready", din_ready, 1'b0);
    check("mid_rst_done", cfg_done, 1'b0);
    check("mid_rst_wraps", cfg_wraps, 16'd0);
    check("mid_rst_err", cfg_err, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
